// File: rtl/sonic_constants_pkg.sv
// Shared SoNIC circular-buffer constants: page geometry, packed-space size,
// page-header field layout and address helpers. Imported by the write-side
// page writer and the read-side external-to-internal translator.
package sonic_constants;

  localparam int NUM_PAGES     = 64;
  localparam int PAGE_WORDS    = 512;
  localparam int HDR_WORDS     = 16;
  localparam int PAYLOAD_WORDS = PAGE_WORDS - HDR_WORDS;   // 496
  localparam int EXT_SPACE     = NUM_PAGES * PAYLOAD_WORDS; // 0x7C00

  localparam int ADDR_W  = 15;  // internal and packed address width
  localparam int PAGE_W  = 6;   // page index width
  localparam int CNT_W   = 9;   // payload words per page, 0..496
  localparam int CRED_W  = 7;   // credit counter, 0..64
  localparam int HDR_W   = 22;  // meaningful bits of header word 0

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HDR
  } wr_state_e;

  // Header word 0 layout; the remaining upper bits of the memory word are zero.
  typedef struct packed {
    logic [PAGE_W-1:0] page;        // [21:16]
    logic [6:0]        rsvd;        // [15:9]
    logic [CNT_W-1:0]  word_count;  // [8:0]
  } page_hdr_t;

  // Internal address of header word 0 of a page.
  function automatic logic [ADDR_W-1:0] page_base(input logic [PAGE_W-1:0] page);
    return {page, 9'd0};
  endfunction

  // Internal address of payload word `off` of a page.
  function automatic logic [ADDR_W-1:0] payload_addr(input logic [PAGE_W-1:0] page,
                                                     input logic [CNT_W-1:0]  off);
    return page_base(page) + ADDR_W'(HDR_WORDS) + ADDR_W'(off);
  endfunction

  // Packed (external) address of the first payload slot of a page.
  function automatic logic [ADDR_W-1:0] ext_base(input logic [PAGE_W-1:0] page);
    return ADDR_W'(page) * ADDR_W'(PAYLOAD_WORDS);
  endfunction

endpackage

// File: rtl/sonic_circbuf_page_writer_credit.sv
// Saturating 0..64 page-credit counter with a sticky over-release flag.
// Latency: count and flag update one cycle after consume/release.
// Backpressure: credit_avail low at zero credits; caller must not consume then.
module sonic_page_credit
  import sonic_constants::*;
(
  input  logic clk,
  input  logic reset,
  input  logic consume,
  input  logic page_release,
  output logic credit_avail,
  output logic credit_err
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(NUM_PAGES);

  logic [CRED_W-1:0] count_q;

  // Net credit update; a release and a consume in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= CRED_MAX;
      credit_err <= 1'b0;
    end else if (consume && !page_release) begin
      count_q <= count_q - 1'b1;
    end else if (page_release && !consume) begin
      if (count_q == CRED_MAX) credit_err <= 1'b1;
      else                     count_q    <= count_q + 1'b1;
    end
  end

  assign credit_avail = (count_q != '0);

endmodule

// File: rtl/sonic_circbuf_page_writer.sv
// Write-side page framer: packs payload into 512-word pages, writes header, publishes ext_wr_ptr.
// Latency: memory write one cycle after acceptance; header one cycle after the last payload write.
// Backpressure: in_ready low during the header cycle and while no page credit is available.
module sonic_circbuf_page_writer
  import sonic_constants::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  rd_page_release,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  page_commit,
  output logic [PAGE_W-1:0]     commit_page,
  output logic [ADDR_W-1:0]     ext_wr_ptr,
  output logic                  credit_err
);

  wr_state_e         state_q, state_d;
  logic [PAGE_W-1:0] cur_page_q, cur_page_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              rst_done_q;
  logic              credit_avail;
  logic              consume;
  logic              accept;

  logic                  wr_en_d, page_commit_d;
  logic [ADDR_W-1:0]     wr_addr_d, ext_wr_ptr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [PAGE_W-1:0]     commit_page_d;
  page_hdr_t             hdr;

  sonic_page_credit u_credit (
    .clk          (clk),
    .reset        (reset),
    .consume      (consume),
    .page_release (rd_page_release),
    .credit_avail (credit_avail),
    .credit_err   (credit_err)
  );

  // Purely registered: held low for the first cycle out of reset.
  assign in_ready = rst_done_q &&
                    ((state_q == ST_IDLE && credit_avail) || state_q == ST_FILL);
  assign accept   = in_valid && in_ready;

  // Next-state and next-output decode for the page FSM.
  always_comb begin
    state_d       = state_q;
    cur_page_d    = cur_page_q;
    word_cnt_d    = word_cnt_q;
    consume       = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    page_commit_d = 1'b0;
    commit_page_d = commit_page;
    ext_wr_ptr_d  = ext_wr_ptr;
    hdr           = '0;
    case (state_q)
      ST_IDLE: begin
        // Opening a page; flush has nothing to close here.
        if (accept) begin
          consume    = 1'b1;
          wr_en_d    = 1'b1;
          wr_addr_d  = payload_addr(cur_page_q, '0);
          wr_data_d  = in_data;
          word_cnt_d = CNT_W'(1);
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = payload_addr(cur_page_q, word_cnt_q);
          wr_data_d  = in_data;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == CNT_W'(PAYLOAD_WORDS - 1) || flush) state_d = ST_HDR;
        end else if (flush) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        hdr.page       = cur_page_q;
        hdr.word_count = word_cnt_q;
        wr_en_d        = 1'b1;
        wr_addr_d      = page_base(cur_page_q);
        wr_data_d      = DATA_WIDTH'(hdr);
        page_commit_d  = 1'b1;
        commit_page_d  = cur_page_q;
        cur_page_d     = cur_page_q + 1'b1;
        ext_wr_ptr_d   = ext_base(cur_page_q + 1'b1);
        word_cnt_d     = '0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any partially filled page.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_page_q  <= '0;
      word_cnt_q  <= '0;
      rst_done_q  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      page_commit <= 1'b0;
      commit_page <= '0;
      ext_wr_ptr  <= '0;
    end else begin
      state_q     <= state_d;
      cur_page_q  <= cur_page_d;
      word_cnt_q  <= word_cnt_d;
      rst_done_q  <= 1'b1;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      page_commit <= page_commit_d;
      commit_page <= commit_page_d;
      ext_wr_ptr  <= ext_wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_sonic_circbuf_page_writer.sv
// Directed bench for sonic_circbuf_page_writer: reset, full page, flush,
// credit stall, simultaneous credit events and mid-page reset.
module tb_sonic_circbuf_page_writer;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          rd_page_release;
  logic          wr_en;
  logic [14:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          page_commit;
  logic [5:0]    commit_page;
  logic [14:0]   ext_wr_ptr;
  logic          credit_err;

  int checks = 0;
  int errors = 0;

  sonic_circbuf_page_writer #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .flush           (flush),
    .rd_page_release (rd_page_release),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .page_commit     (page_commit),
    .commit_page     (commit_page),
    .ext_wr_ptr      (ext_wr_ptr),
    .credit_err      (credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; rd_page_release = 1'b0; in_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; rd_page_release = 1'b0; in_data = '0;
    tick(); tick();
    checks++;
    if ({wr_en, wr_addr, wr_data, page_commit, commit_page, ext_wr_ptr, credit_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%h data=%h pc=%b cp=%0d ptr=%h err=%b want all zero",
               wr_en, wr_addr, wr_data, page_commit, commit_page, ext_wr_ptr, credit_err);
    end
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_first got %b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_full_page();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 496; i++) begin
      in_data = DW'(32'hA000 + i);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 15'(16 + i) || wr_data !== DW'(32'hA000 + i) || page_commit !== 1'b0) begin
        errors++;
        $display("FAIL full_write[%0d] got en=%b addr=%h data=%h pc=%b want en=1 addr=%h data=%h pc=0",
                 i, wr_en, wr_addr, wr_data, page_commit, 15'(16 + i), DW'(32'hA000 + i));
      end
    end
    in_data = DW'(32'hBEEF);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hdr_ready got %b want 0", in_ready); end
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h000 || wr_data !== DW'(32'h1F0) ||
        page_commit !== 1'b1 || commit_page !== 6'd0 || ext_wr_ptr !== 15'h01F0) begin
      errors++;
      $display("FAIL full_header got en=%b addr=%h data=%h pc=%b cp=%0d ptr=%h want 1 000 1f0 1 0 01f0",
               wr_en, wr_addr, wr_data, page_commit, commit_page, ext_wr_ptr);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b want 1", in_ready); end
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h210 || page_commit !== 1'b0) begin
      errors++;
      $display("FAIL full_next_page got en=%b addr=%h pc=%b want 1 210 0", wr_en, wr_addr, page_commit);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; flush = (i == 4); in_data = DW'(i + 7);
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 15'(16 + i)) begin
        errors++; $display("FAIL flush_write[%0d] got en=%b addr=%h want 1 %h", i, wr_en, wr_addr, 15'(16 + i));
      end
    end
    in_valid = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h000 || wr_data !== DW'(5) || page_commit !== 1'b1 || ext_wr_ptr !== 15'h01F0) begin
      errors++;
      $display("FAIL flush_header got en=%b addr=%h data=%h pc=%b ptr=%h want 1 000 5 1 01f0",
               wr_en, wr_addr, wr_data, page_commit, ext_wr_ptr);
    end
    in_valid = 1'b1;
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h210) begin
      errors++; $display("FAIL flush_next got en=%b addr=%h want 1 210", wr_en, wr_addr);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_credit_stall();
    do_reset();
    in_valid = 1'b1;
    for (int p = 0; p < 64; p++) begin
      for (int w = 0; w < 496; w++) begin
        in_data = DW'(p * 1000 + w);
        tick();
      end
      tick();
      checks++;
      if (page_commit !== 1'b1 || commit_page !== 6'(p) || ext_wr_ptr !== 15'(((p + 1) % 64) * 496)) begin
        errors++;
        $display("FAIL stall_commit[%0d] got pc=%b cp=%0d ptr=%h want 1 %0d %h",
                 p, page_commit, commit_page, ext_wr_ptr, p, 15'(((p + 1) % 64) * 496));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); end
      tick();
      checks++;
      if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_no_write[%0d] got %b want 0", i, wr_en); end
    end
    rd_page_release = 1'b1;
    tick();
    rd_page_release = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h0010) begin
      errors++; $display("FAIL stall_resume got en=%b addr=%h want 1 0010", wr_en, wr_addr);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    in_valid = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; tick();
    checks++;
    if (page_commit !== 1'b1 || wr_data !== DW'(1)) begin
      errors++; $display("FAIL simul_first_hdr got pc=%b data=%h want 1 1", page_commit, wr_data);
    end
    in_valid = 1'b1; rd_page_release = 1'b1; tick();
    in_valid = 1'b0; rd_page_release = 1'b0;
    checks++;
    if (wr_addr !== 15'h210) begin errors++; $display("FAIL simul_open_addr got %h want 210", wr_addr); end
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    checks++;
    if (page_commit !== 1'b1 || commit_page !== 6'd1) begin
      errors++; $display("FAIL simul_second_hdr got pc=%b cp=%0d want 1 1", page_commit, commit_page);
    end
    // Credits should now be 63: one release reaches 64, the next overflows.
    rd_page_release = 1'b1; tick(); rd_page_release = 1'b0;
    checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL simul_err_at_63 got %b want 0", credit_err); end
    rd_page_release = 1'b1; tick(); rd_page_release = 1'b0;
    checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL simul_err_at_64 got %b want 1", credit_err); end
    tick(); tick(); tick();
    checks++;
    if (credit_err !== 1'b1) begin errors++; $display("FAIL simul_err_sticky got %b want 1", credit_err); end
    do_reset();
    checks++;
    if (credit_err !== 1'b0) begin errors++; $display("FAIL simul_err_cleared got %b want 0", credit_err); end
  endtask

  task automatic test_reset_mid_page();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = DW'(i);
      tick();
    end
    checks++;
    if (wr_addr !== 15'h0073) begin errors++; $display("FAIL midrst_last_addr got %h want 0073", wr_addr); end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || ext_wr_ptr !== 15'h0) begin
      errors++; $display("FAIL midrst_state got rdy=%b ptr=%h want 0 0000", in_ready, ext_wr_ptr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wr_en !== 1'b0 || page_commit !== 1'b0 || ext_wr_ptr !== 15'h0) begin
        errors++; $display("FAIL midrst_quiet[%0d] got en=%b pc=%b ptr=%h want 0 0 0000", i, wr_en, page_commit, ext_wr_ptr);
      end
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h0010) begin
      errors++; $display("FAIL midrst_resume got en=%b addr=%h want 1 0010", wr_en, wr_addr);
    end
  endtask

  initial begin
    test_reset();
    test_full_page();
    test_flush();
    test_credit_stall();
    test_simultaneous();
    test_reset_mid_page();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_circbuf_page_writer.md
# sonic_circbuf_page_writer

Write-side address generator and page framer for the SoNIC circular buffer. It accepts a stream of payload words and writes them into the 64-page internal buffer memory. Each page is 512 words: a 16-word header region at the page base, followed by 496 payload words. The block writes a header word when each page closes, publishes the committed packed (external) write pointer to the read side, and stalls on page credits returned by the reader. It is the producer counterpart of the read-side external-to-internal address translator.

## Interface
- DATA_WIDTH, 128: payload / memory word width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  payload word.
- in_valid  in  1  payload word present.
- in_ready  out  1  block accepts in_data this cycle.
- flush  in  1  close the open page early (level sampled per cycle).
- rd_page_release  in  1  one-cycle pulse; reader has freed one page.
- wr_en  out  1  memory write strobe.
- wr_addr  out  15  internal memory address.
- wr_data  out  DATA_WIDTH  memory write data.
- page_commit  out  1  one-cycle pulse; page header written.
- commit_page  out  6  index of the page committed with page_commit.
- ext_wr_ptr  out  15  committed packed write pointer, range 0..0x7BFF.
- credit_err  out  1  sticky; a release arrived with credits already at 64.

## Operation
- Constants: 64 pages, 512 words per page, 16 header words, 496 payload words, packed space 0x7C00 words.
- Page p (0..63): header at p*0x200; payload offset k (0..495) at p*0x200 + 0x10 + k; packed address p*496 + k.
- Credit counter 0..64, reset value 64. Opening a page consumes one credit; rd_page_release adds one. Consume and release in the same cycle leave the count unchanged. A release at 64 saturates and sets credit_err.
- FSM:
  - IDLE: no page open. in_ready = (credits > 0). An accepted word opens page cur_page, consumes a credit, is written at offset 0, and moves to FILL. flush is ignored in IDLE.
  - FILL: in_ready = 1. Each accepted word increments the offset. Go to HDR when offset 495 is accepted, or when flush is high with at least one word in the page. A word accepted in the same cycle as flush belongs to the closing page.
  - HDR: in_ready = 0. Write header word 0 at cur_page*0x200. wr_data = zero-extended {cur_page[5:0] at [21:16], word_count[8:0] at [8:0]}, where word_count is 1..496. Header words 1..15 are never written. Assert page_commit with commit_page = cur_page. Set ext_wr_ptr = ((cur_page+1) mod 64)*496 and cur_page = (cur_page+1) mod 64. Then go to IDLE.
- Early-closed pages skip their unused packed slots. The reader uses word_count from the header.
- Page 63 wraps to page 0. ext_wr_ptr wraps 0x7A10 -> 0x0000.

## Timing
- Outputs are registered. wr_en/wr_addr/wr_data appear one cycle after the accepting edge (in_valid & in_ready).
- The header write occurs in the cycle after the final payload write. page_commit and the new ext_wr_ptr are valid in that same cycle.
- Maximum throughput is 496 payload words per 497 cycles.
- Reset values: in_ready 0 in the first cycle after reset, then 1 (credits 64). wr_en 0, wr_addr 0, wr_data 0, page_commit 0, commit_page 0, ext_wr_ptr 0, credit_err 0. Internal state: cur_page 0, offset 0, state IDLE.
- Reset asserted mid-page discards the open page. No header is written for it.
- in_ready depends only on registered state, never combinationally on in_valid.

## Structure
- Add to the shared sonic_constants package: PAGE_WORDS, HDR_WORDS, PAYLOAD_WORDS, NUM_PAGES, EXT_SPACE, and a page-header field layout typedef. The read-side translator uses the same package.
- One sub-module: sonic_page_credit, the saturating 0..64 credit counter with the credit_err flag.

## Test plan
- Full page: 496 back-to-back words starting after reset.
  - Expected writes: addresses 0x010..0x1FF.
  - Next cycle: header write at 0x000 with data 0x1F0, page_commit=1, commit_page=0, ext_wr_ptr=0x01F0.
  - in_ready is 0 for exactly one cycle.
- Flush: 5 words into page 0, with flush high on the 5th.
  - Expected: header at 0x000 with data 0x005, ext_wr_ptr=0x01F0.
  - The next word is written at 0x210.
- Credit stall: 64 full pages with no releases.
  - Expected: in_ready stays 0 after the 64th commit.
  - A single rd_page_release re-asserts in_ready, and the next word is written at 0x0010 (page 0).
  - The 64th commit shows commit_page=63 and ext_wr_ptr=0x0000.
- Simultaneous events: release and page open in the same cycle keep credits at 63.
  - Separately, a release at 64 credits sets credit_err, which stays high until reset.
- Reset mid-page: reset after 100 words.
  - Expected: no header write and ext_wr_ptr=0.
  - The next word is written at 0x0010.
